// File: rtl/alu_shift_pkg.sv
// Shared encodings for the sequential shift/rotate unit: operation modes,
// FSM state codes, flag bit positions and a flag packing helper.
package alu_shift_pkg;

    localparam logic [2:0] MODE_ROR = 3'b000;
    localparam logic [2:0] MODE_ROL = 3'b001;
    localparam logic [2:0] MODE_LSR = 3'b010;
    localparam logic [2:0] MODE_LSL = 3'b011;
    localparam logic [2:0] MODE_ASR = 3'b100;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic v, input logic c);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/shift_step_n_bit.sv
// Combinational step: moves wr by k (0..STEP) positions in the given mode,
// reporting the last bit that left the word and any LSL sign change.
module shift_step_n_bit
    import alu_shift_pkg::*;
#(
    parameter int N    = 8,
    parameter int STEP = 1,
    localparam int SW  = $clog2(N) + 1
) (
    input  logic [N-1:0]  wr,
    input  logic [2:0]    mode,
    input  logic [SW-1:0] k,
    output logic [N-1:0]  wr_next,
    output logic          c_out,
    output logic          sign_chg
);

    logic [N-1:0] w;
    logic         c;
    logic         sc;

    always_comb begin
        w  = wr;
        c  = 1'b0;
        sc = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(k)) begin
                case (mode)
                    MODE_ROR: begin c = w[0];   w = {w[0], w[N-1:1]};   end
                    MODE_ROL: begin c = w[N-1]; w = {w[N-2:0], w[N-1]}; end
                    MODE_LSR: begin c = w[0];   w = {1'b0, w[N-1:1]};   end
                    MODE_LSL: begin
                        c = w[N-1];
                        // The new MSB is the old bit N-2; any difference is a sign change.
                        if (w[N-1] != w[N-2]) sc = 1'b1;
                        w = {w[N-2:0], 1'b0};
                    end
                    MODE_ASR: begin c = w[0];   w = {w[N-1], w[N-1:1]}; end
                    default: ;
                endcase
            end
        end
        wr_next  = w;
        c_out    = c;
        sign_chg = sc;
    end

endmodule

// File: rtl/shift_rotate_unit_seq.sv
// Multi-cycle N-bit shift/rotate unit moving up to STEP positions per clock,
// producing {n,z,v,c} flags alongside the registered result.
module shift_rotate_unit_seq
    import alu_shift_pkg::*;
#(
    parameter int N    = 8,
    parameter int STEP = 1,
    parameter int SW   = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [N-1:0]  in_a,
    input  logic [SW-1:0] shift,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  out,
    output logic [3:0]    flags_n_z_v_c
);

    localparam int LW = $clog2(N);

    // Handshake: start is accepted only when busy=0 (IDLE or DONE); busy is
    // high from the cycle after acceptance until done; done is a one-cycle
    // pulse and out/flags are held until the next acceptance.
    logic [1:0]    state;
    logic [N-1:0]  wr;
    logic [2:0]    mode_r;
    logic [SW-1:0] cnt;
    logic          v_r;

    logic [SW-1:0] cnt_eff;
    logic [SW-1:0] k;
    logic [N-1:0]  wr_next;
    logic          c_step;
    logic          sc_step;

    always_comb begin
        cnt_eff = '0;
        case (mode)
            MODE_ROR, MODE_ROL: cnt_eff = {1'b0, shift[LW-1:0]};
            MODE_LSR, MODE_LSL, MODE_ASR:
                cnt_eff = (shift > SW'(N)) ? SW'(N) : shift;
            default: cnt_eff = '0;
        endcase
    end

    always_comb begin
        k = (cnt > SW'(STEP)) ? SW'(STEP) : cnt;
    end

    shift_step_n_bit #(.N(N), .STEP(STEP)) u_step (
        .wr       (wr),
        .mode     (mode_r),
        .k        (k),
        .wr_next  (wr_next),
        .c_out    (c_step),
        .sign_chg (sc_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr            <= '0;
            mode_r        <= '0;
            cnt           <= '0;
            v_r           <= 1'b0;
            out           <= '0;
            flags_n_z_v_c <= 4'b0000;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        wr     <= in_a;
                        mode_r <= mode;
                        cnt    <= cnt_eff;
                        v_r    <= 1'b0;
                        if (cnt_eff == '0) begin
                            state         <= DONE;
                            out           <= in_a;
                            flags_n_z_v_c <= pack_flags(in_a[N-1], in_a == '0, 1'b0, 1'b0);
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    wr  <= wr_next;
                    cnt <= cnt - k;
                    v_r <= v_r | sc_step;
                    if (cnt == k) begin
                        state         <= DONE;
                        out           <= wr_next;
                        flags_n_z_v_c <= pack_flags(wr_next[N-1], wr_next == '0,
                                                    v_r | sc_step, c_step);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: doc/shift_rotate_unit_seq.md
Name: shift_rotate_unit_seq

Overview:
- Multi-cycle, parametrised shift/rotate unit for the ALU.
- Generalises the combinational 8-bit right rotater to N bits and five modes: ROR, ROL, LSR, LSL and ASR.
- Processes up to STEP bit positions per clock and uses a start/busy/done handshake.
- Produces the ALU-standard flags_n_z_v_c on completion, so the control FSM can trade area against latency.

Parameters:
- N, 8, datapath width. Must be a power of 2 and at least 4.
- STEP, 1, maximum bit positions moved per RUN cycle. Range 1..N.
- SW, $clog2(N)+1, width of the shift-amount port. Derived; never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request pulse. Accepted only when busy=0.
- mode  in  3  000=ROR, 001=ROL, 010=LSR, 011=LSL, 100=ASR. All other codes are illegal.
- in_a  in  N  operand. Sampled when start is accepted.
- shift  in  SW  shift amount. Sampled when start is accepted.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle completion pulse.
- out  out  N  result. Registered; held until the next acceptance.
- flags_n_z_v_c  out  4  {n,z,v,c}. Registered; held with out.

Behaviour:
- Reset, on any clk edge with rst_n=0, including mid-operation:
  - state=IDLE; busy=0, done=0, out=0, flags_n_z_v_c=0.
  - Any in-flight operation is discarded.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, for exactly one cycle. Next state is IDLE, unless start is accepted in that same cycle, in which case the new operation is loaded.
- Acceptance: start=1 while in IDLE or DONE.
  - Latch in_a into the working register wr, mode, and the effective count cnt.
  - Clear the sticky v and the c register.
  - If cnt==0, next state is DONE. Otherwise next state is RUN.
- start while busy=1 is ignored: no state change, no error.
- Effective count:
  - Rotates: shift mod N.
  - Shifts: min(shift, N). Shifting by N yields all zeros for LSR/LSL and all sign bits for ASR.
- Each RUN cycle:
  - Move k = min(STEP, cnt) positions; cnt -= k.
  - c <= the last bit that crossed the word boundary in this step.
  - LSL only: v is set if the MSB of wr takes any different value during the step (sign change).
  - When cnt reaches 0, next state is DONE.
- Latency: done asserts 1 + ceil(cnt/STEP) cycles after the acceptance edge, with the acceptance edge counting as cycle 0.
- out and flags update on the edge that enters DONE.
- Flags:
  - n = out[N-1].
  - z = (out==0).
  - v = sticky sign-change bit for LSL; 0 for all other modes.
  - c = last bit shifted or rotated out. c=0 when the effective count is 0.
- Rotates with a count that is a multiple of N: out=in_a, c=0, 1-cycle latency.
- Illegal mode: treated as count 0. out=in_a, v=0, c=0; n and z are computed from in_a.

Decomposition:
- Package alu_shift_pkg:
  - mode encodings MODE_ROR, MODE_ROL, MODE_LSR, MODE_LSL, MODE_ASR.
  - state enum IDLE/RUN/DONE.
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0.
- Sub-module shift_step_n_bit (parametrised N, STEP):
  - Combinational; moves wr by k (0..STEP) in a given mode.
  - Returns the next wr, the last out-going bit, and a sign-change indication.
  - The top level holds the FSM, the count and the registers.

Test Plan (N=8 unless stated):
- ROR in_a=11110000, shift=3, STEP=1 -> done 4 cycles after start; out=00011110, flags=0000.
- ROL in_a=10000001, shift=1 -> done 2 cycles after start; out=00000011, flags=0001.
- ASR in_a=10010000:
  - shift=2 -> out=11100100, flags=1000.
  - shift=5 -> out=11111100, flags=1001.
- LSL and LSR:
  - LSL in_a=01000000, shift=1 -> out=10000000, flags=1010.
  - LSR in_a=11110000, shift=8, STEP=1 -> done at cycle 9; out=00000000, flags=0101.
- ROR in_a=10100101, shift=8 -> done 1 cycle after start; out=10100101, flags=1000.
  - Then start while busy is ignored; the second op still completes with its own values.
  - rst_n=0 mid-RUN -> next edge gives busy=0, out=0, flags=0000, no done.
- STEP=3, ROR in_a=11110000, shift=6 -> exactly 2 RUN cycles, done at cycle 3; out=11000011, flags=1001.
  - Back-to-back start in the DONE cycle is accepted; busy is high on the next cycle.
